uart_rx_byte: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_byte.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants,
// the baud divider derivation used by both transmitter and receiver, and the vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] SAMPLE_LO   = 4'd7;
  localparam logic [3:0] SAMPLE_MID  = 4'd8;
  localparam logic [3:0] SAMPLE_HI   = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'd15;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable via clr
// so that ticks stay phase-aligned to the detected start edge.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic tick
);

  localparam logic [9:0] TICK_LAST = 10'(DIV - 1);

  logic [9:0] cnt_r;
  logic       tick_r;

  // Divider counter; the tick is registered on the wrap cycle
  always_ff @(posedge clk) begin
    if (reset_p || clr) begin
      cnt_r  <= 10'd0;
      tick_r <= 1'b0;
    end else if (cnt_r == TICK_LAST) begin
      cnt_r  <= 10'd0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + 10'd1;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 16x oversampling and 3-sample majority vote,
// delivering bytes through a valid/acknowledge register with frame-error and overrun flags.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);

  uart_state_e state_r, state_nxt_s;
  logic        rx_meta_r, rx_sync_r;
  logic        tick_s, clr_s;
  logic [3:0]  s_r, s_nxt_s;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic        smp_lo_r, smp_mid_r, maj_s;
  logic        at_lo_s, at_mid_s, at_hi_s, at_last_s;
  logic        shift_s, idx_inc_s, load_s, ferr_s;
  logic [7:0]  data_r;
  logic        data_valid_r, frame_err_r, overrun_r, busy_r;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (clr_s),
    .tick   (tick_s)
  );

  // Sample events are named by the value s takes on that tick
  assign s_nxt_s   = s_r + 4'd1;
  assign at_lo_s   = tick_s && (s_nxt_s == SAMPLE_LO);
  assign at_mid_s  = tick_s && (s_nxt_s == SAMPLE_MID);
  assign at_hi_s   = tick_s && (s_nxt_s == SAMPLE_HI);
  assign at_last_s = tick_s && (s_nxt_s == SAMPLE_LAST);
  assign maj_s     = majority3(smp_lo_r, smp_mid_r, rx_sync_r);

  // Input synchroniser and FSM state register
  always_ff @(posedge clk) begin
    if (reset_p) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      state_r   <= IDLE;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      state_r   <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_sync_r) state_nxt_s = START;
        else            state_nxt_s = IDLE;
      end
      START: begin
        if (at_hi_s && maj_s) state_nxt_s = IDLE;
        else if (at_last_s)   state_nxt_s = DATA;
        else                  state_nxt_s = START;
      end
      DATA: begin
        if (at_last_s && (bit_idx_r == 3'd7)) state_nxt_s = STOP;
        else                                  state_nxt_s = DATA;
      end
      STOP: begin
        if (at_hi_s) state_nxt_s = maj_s ? IDLE : WAIT_IDLE;
        else         state_nxt_s = STOP;
      end
      WAIT_IDLE: begin
        if (rx_sync_r) state_nxt_s = IDLE;
        else           state_nxt_s = WAIT_IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    clr_s     = 1'b0;
    shift_s   = 1'b0;
    idx_inc_s = 1'b0;
    load_s    = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      IDLE:      clr_s = 1'b1;
      START:     clr_s = 1'b0;
      DATA: begin
        shift_s   = at_hi_s;
        idx_inc_s = at_last_s;
      end
      STOP: begin
        load_s = at_hi_s & maj_s;
        ferr_s = at_hi_s & ~maj_s;
      end
      WAIT_IDLE: clr_s = 1'b1;
      default:   clr_s = 1'b1;
    endcase
  end

  // Sample counter, vote samples, bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (reset_p) begin
      s_r       <= 4'd0;
      smp_lo_r  <= 1'b1;
      smp_mid_r <= 1'b1;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (clr_s)       s_r <= 4'd0;
      else if (tick_s) s_r <= s_nxt_s;
      if (at_lo_s)  smp_lo_r  <= rx_sync_r;
      if (at_mid_s) smp_mid_r <= rx_sync_r;
      if (state_r != DATA) bit_idx_r <= 3'd0;
      else if (idx_inc_s)  bit_idx_r <= bit_idx_r + 3'd1;
      if (shift_s) shift_r <= {maj_s, shift_r[7:1]};
    end
  end

  // Output register and handshake; a load in the acknowledge cycle keeps overrun as is
  always_ff @(posedge clk) begin
    if (reset_p) begin
      data_r       <= 8'h00;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      busy_r      <= (state_nxt_s != IDLE);
      if (load_s) begin
        data_r       <= shift_r;
        data_valid_r <= 1'b1;
        if (data_valid_r && !rd_en) overrun_r <= 1'b1;
      end else if (rd_en) begin
        data_valid_r <= 1'b0;
        overrun_r    <= 1'b0;
      end
    end
  end

  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random frames,
// checked against a byte-level handshake model. Runs at a scaled-down baud divider.
module tb_uart_rx_byte;

  localparam int CLK_HZ = 1280;
  localparam int BAUD   = 10;
  localparam int D      = CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * D;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data;
  logic       data_valid, frame_err, overrun, busy;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   ferr_total = 0;
  int   busy_total = 0;
  int   start_cyc = 0;
  logic dv_prev = 1'b0;

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .rx        (rx),
    .rd_en     (rd_en),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    dv_prev <= data_valid;
    if (data_valid && !dv_prev) rise_cyc <= cyc;
    ferr_total <= ferr_total + int'(frame_err);
    busy_total <= busy_total + int'(busy);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic rx_hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx = v;
    end
  endtask

  // Model: a good frame lands in the holding register, overrunning if unread
  task automatic model_rx(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    m_data  = b;
    m_valid = 1'b1;
  endtask

  task automatic rd_pulse();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_data"}, {24'd0, data}, {24'd0, m_data});
    check_eq({tag, "_valid"}, {31'd0, data_valid}, {31'd0, m_valid});
    check_eq({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  // Drive one 8N1 frame; optionally invert one bit around its centre sample,
  // or stop driving at the middle of bit abort_bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int glitch_bit, input int abort_bit);
    logic [9:0] bits;
    logic       aborted;
    bits    = {stop_bit, b, 1'b0};
    aborted = 1'b0;
    for (int n = 0; n < 10 && !aborted; n++) begin
      for (int c = 0; c < BIT && !aborted; c++) begin
        @(posedge clk);
        #1;
        if (n == abort_bit && c == 8 * D) begin
          aborted = 1'b1;
        end else begin
          if (n == 0 && c == 0) start_cyc = cyc;
          if (n == glitch_bit && c >= 8 * D - D / 2 && c < 8 * D + D / 2) rx = ~bits[n];
          else rx = bits[n];
        end
      end
    end
  endtask

  initial begin
    int         fe0;
    int         bz0;
    int         lat;
    int         g;
    int         gap;
    logic       bad;
    logic [7:0] b;

    reset_p = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_p = 1'b0;
    settle();
    check_eq("rst_data", {24'd0, data}, 32'h0000_0000);
    check_eq("rst_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rx_hold(1'b1, BIT);

    // Single clean frame with latency check
    fe0 = ferr_total;
    send_frame(8'hA5, 1'b1, -1, -1);
    model_rx(8'hA5);
    settle();
    check_model("a5");
    check_eq("a5_ferr", 32'(ferr_total - fe0), 32'd0);
    check_eq("a5_busy", {31'd0, busy}, 32'd0);
    lat = rise_cyc - start_cyc;
    check_eq("a5_latency_window", {31'd0, (lat >= 153 * D) && (lat <= 153 * D + 8)}, 32'd1);
    rd_pulse();
    settle();
    check_model("a5_ack");

    // False start: short low pulse
    bz0 = busy_total;
    rx_hold(1'b0, 5 * D);
    rx_hold(1'b1, 2 * BIT);
    settle();
    check_eq("fs_busy_seen", {31'd0, busy_total > bz0}, 32'd1);
    check_eq("fs_busy_end", {31'd0, busy}, 32'd0);
    check_model("fs");

    // Framing error, line held low, then recovery
    fe0 = ferr_total;
    send_frame(8'h3C, 1'b0, -1, -1);
    rx_hold(1'b0, 2 * BIT);
    settle();
    check_eq("fe_pulse_len", 32'(ferr_total - fe0), 32'd1);
    check_eq("fe_wait_busy", {31'd0, busy}, 32'd1);
    check_model("fe");
    rx_hold(1'b1, BIT);
    settle();
    check_eq("fe_idle_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h55, 1'b1, -1, -1);
    model_rx(8'h55);
    settle();
    check_model("fe_next");
    rd_pulse();

    // Back-to-back frames without acknowledge
    send_frame(8'h3C, 1'b1, -1, -1);
    model_rx(8'h3C);
    send_frame(8'hC3, 1'b1, -1, -1);
    model_rx(8'hC3);
    rx_hold(1'b1, D);
    settle();
    check_model("ovr");
    rd_pulse();
    settle();
    check_model("ovr_ack");

    // Reset in the middle of data bit 4
    send_frame(8'h5A, 1'b1, -1, -1);
    model_rx(8'h5A);
    send_frame(8'h81, 1'b1, -1, 5);
    reset_p = 1'b1;
    rx      = 1'b1;
    @(posedge clk);
    #1 reset_p = 1'b0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    settle();
    check_model("midrst");
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_ferr", {31'd0, frame_err}, 32'd0);
    rx_hold(1'b1, BIT);
    settle();
    check_model("midrst_quiet");
    send_frame(8'h7E, 1'b1, -1, -1);
    model_rx(8'h7E);
    settle();
    check_model("after_rst");
    rd_pulse();

    // Glitch at the centre sample of a data bit
    send_frame(8'hFF, 1'b1, 3, -1);
    model_rx(8'hFF);
    settle();
    check_model("glitch");
    rd_pulse();

    // Random frames, glitches, framing errors and acknowledges
    for (int i = 0; i < 20; i++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 9) == 0);
      g   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1;
      fe0 = ferr_total;
      send_frame(b, ~bad, g, -1);
      if (bad) begin
        rx_hold(1'b1, BIT / 2);
      end else begin
        model_rx(b);
        gap = int'($urandom_range(0, BIT / 2));
        rx_hold(1'b1, gap);
      end
      settle();
      check_model("rnd");
      check_eq("rnd_ferr", 32'(ferr_total - fe0), {31'd0, bad});
      if ($urandom_range(0, 1) == 1) rd_pulse();
    end

    rx_hold(1'b1, BIT);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
